// File: rtl/bus_drvr_fifo.sv
// Per-driver show-ahead transmit FIFO between a driver agent and the shared bus.
// Define BUS_FIFO_STATS_EN to add push/pop/drop counters and a constant driver-id port.
module bus_drvr_fifo #(
  parameter int PCKG_SZ = 16,
  parameter int DEPTH   = 10,
  parameter int DRVRS   = 4,
  parameter int DRVR_ID = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [PCKG_SZ-1:0]         D_push,
  input  logic                       pop,
  output logic [PCKG_SZ-1:0]         D_pop,
  output logic                       pndng,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       udf
`ifdef BUS_FIFO_STATS_EN
  ,
  output logic [15:0]                push_cnt,
  output logic [15:0]                pop_cnt,
  output logic [15:0]                drop_cnt,
  output logic [((DRVRS > 1) ? $clog2(DRVRS) : 1)-1:0] drvr_id
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  logic [PCKG_SZ-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_nxt_s;
  logic               ovf_r;
  logic               udf_r;
  logic               push_ok_s;
  logic               pop_ok_s;
  logic               ovf_set_s;
  logic               udf_set_s;

  // DEPTH need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  // Accept/flag decode and next occupancy; a pop at full frees the slot the push reuses.
  always_comb begin
    pop_ok_s    = pop && (count_r != CNT_ZERO);
    push_ok_s   = push && ((count_r != CNT_FULL) || pop);
    ovf_set_s   = push && !push_ok_s;
    udf_set_s   = pop && !pop_ok_s;
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and sticky error flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
      if (udf_set_s) begin
        udf_r <= 1'b1;
      end
    end
  end

  // Packet storage; reset leaves contents alone since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= D_push;
    end
  end

  // Show-ahead head; forced to zero when empty so stale storage never leaks out.
  always_comb begin
    if (count_r != CNT_ZERO) begin
      D_pop = mem_r[rd_ptr_r];
    end else begin
      D_pop = {PCKG_SZ{1'b0}};
    end
  end

  assign count = count_r;
  assign pndng = (count_r != CNT_ZERO);
  assign full  = (count_r == CNT_FULL);
  assign ovf   = ovf_r;
  assign udf   = udf_r;

`ifdef BUS_FIFO_STATS_EN
  localparam int ID_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  logic [15:0] push_cnt_r;
  logic [15:0] pop_cnt_r;
  logic [15:0] drop_cnt_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'h0001;
    end
  endfunction

  // Saturating activity counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_cnt_r <= 16'h0000;
      pop_cnt_r  <= 16'h0000;
      drop_cnt_r <= 16'h0000;
    end else begin
      if (push_ok_s) begin
        push_cnt_r <= sat_inc(push_cnt_r);
      end
      if (pop_ok_s) begin
        pop_cnt_r <= sat_inc(pop_cnt_r);
      end
      if (ovf_set_s) begin
        drop_cnt_r <= sat_inc(drop_cnt_r);
      end
    end
  end

  assign push_cnt = push_cnt_r;
  assign pop_cnt  = pop_cnt_r;
  assign drop_cnt = drop_cnt_r;
  assign drvr_id  = ID_W'(DRVR_ID);
`endif

endmodule

// File: doc/bus_drvr_fifo.md
Name: bus_drvr_fifo

Overview:
- Per-driver transmit FIFO sitting between a driver-side agent and the shared bus; one instance per driver, drvrs instances total.
- Accepts packets of pckg_sz bits from the agent, buffers up to fif_Size of them, and presents the head packet plus a pending flag to the bus.
- Bus-side pop consumes the head. Show-ahead, single clock.

Parameters:
- PCKG_SZ, 16, packet width in bits.
- DEPTH, 10, FIFO capacity in packets; need not be a power of two; legal range 2..1024.
- DRVR_ID, 0, driver index 0..drvrs-1; used only by the stats feature.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- push  input  1  agent writes D_push this cycle.
- D_push  input  PCKG_SZ  packet from agent.
- pop  input  1  bus consumes head packet this cycle.
- D_pop  output  PCKG_SZ  head packet; all-zero when empty.
- pndng  output  1  FIFO non-empty.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH+1)  current occupancy.
- ovf  output  1  sticky: a push was dropped.
- udf  output  1  sticky: a pop arrived while empty.

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release): wr_ptr = 0, rd_ptr = 0, count = 0, ovf = 0, udf = 0.
  - Outputs during reset: pndng = 0, full = 0, D_pop = 0.
  - Storage array is not cleared.
  - Reset asserted mid-operation discards all buffered packets immediately.
- Pointers run 0..DEPTH-1. Increment at DEPTH-1 wraps to 0 by explicit compare; no modulo-2^n assumption.
- Cycle actions by count and {push, pop}:
  - count==0, push only: write at wr_ptr, wr_ptr++, count = 1.
  - count==0, pop only: ignored; udf <= 1.
  - count==0, push and pop: push proceeds; pop ignored; udf <= 1; count = 1. No fall-through.
  - 0<count<DEPTH, push only: write, count+1.
  - 0<count<DEPTH, pop only: rd_ptr++, count-1.
  - 0<count<DEPTH, push and pop: both proceed; count unchanged.
  - count==DEPTH, push only: packet dropped; ovf <= 1; state unchanged.
  - count==DEPTH, push and pop: both proceed; count stays DEPTH; no ovf.
  - count==DEPTH, pop only: count-1.
- Latency and derived outputs:
  - A push at edge N makes the packet visible on D_pop after edge N if the FIFO was empty.
  - pndng, full and count update after the same edge.
  - D_pop = mem[rd_ptr] when count != 0, else 0; combinational from registered state.
  - pndng = (count != 0); full = (count == DEPTH). Both are decoded from the registered count only, with no input-to-output combinational path.
- ovf and udf clear only on reset.
- Bus handshake: the bus may assert pop only while pndng = 1. A violating pop is tolerated and flagged by udf as above.

Optional Feature:
- Macro: BUS_FIFO_STATS_EN.
- Defined adds output ports:
  - push_cnt  output  16: accepted pushes.
  - pop_cnt  output  16: accepted pops.
  - drop_cnt  output  16: dropped pushes.
  - drvr_id  output  $clog2(drvrs): constant DRVR_ID.
- Counter rules:
  - Counters saturate at 16'hFFFF and reset to 0.
  - A simultaneous push and pop at full increments both push_cnt and pop_cnt.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset then idle 5 cycles -> pndng=0, full=0, count=0, D_pop=16'h0000, ovf=0, udf=0.
- Push 16'hA001; next cycle -> pndng=1, D_pop=16'hA001, count=1. Pop -> count=0, D_pop=0.
- Push 10 packets 16'h0001..16'h000A, then an 11th (16'h00FF) -> full=1, count=10, ovf=1. Popping 10 times yields 0001..000A in order; 00FF never appears.
- Wrap check: push 7, pop 7, then push 8, pop 8 -> data in order across the pointer wrap at index 9->0; count ends 0.
- Pop with FIFO empty, in the same cycle as push 16'h5555 -> udf=1, count=1, D_pop=16'h5555.
- Fill to 10, then 3 cycles of simultaneous push/pop -> count stays 10, ovf=0, heads pop in FIFO order. Assert reset mid-sequence -> count=0, pndng=0 immediately. With BUS_FIFO_STATS_EN: push_cnt=13, pop_cnt=3 before reset, 0 after.
